// File: rtl/ap_ctrl_perf_monitor.sv
// Per-channel ap_ctrl handshake monitor: latency, interval, stall and
// transaction counters with a registered read port and a sticky freeze.
module ap_ctrl_perf_monitor #(
  parameter int NUM_CH = 2,
  parameter int CNT_W  = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [NUM_CH-1:0] ch_ap_start,
  input  logic [NUM_CH-1:0] ch_ap_done,
  input  logic [NUM_CH-1:0] ch_ap_continue,
  input  logic              finish,
  input  logic              clear,
  input  logic              rd_en,
  input  logic [2:0]        rd_ch,
  input  logic [2:0]        rd_sel,
  output logic              rd_valid,
  output logic [CNT_W-1:0]  rd_data,
  output logic [NUM_CH-1:0] ch_busy,
  output logic              frozen
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_WAIT = 2'd2
  } st_e;

  // Saturating increment; MSB flags an attempted wrap.
  function automatic logic [CNT_W:0] sinc(input logic [CNT_W-1:0] v);
    return (&v) ? {1'b1, v} : {1'b0, v + CNT_W'(1)};
  endfunction

  logic frozen_q, frozen_d;
  logic freeze;

  assign freeze   = frozen_q | finish;
  assign frozen_d = clear ? 1'b0 : (frozen_q | finish);
  assign frozen   = frozen_q;

  logic [CNT_W-1:0] txn_a   [NUM_CH];
  logic [CNT_W-1:0] last_a  [NUM_CH];
  logic [CNT_W-1:0] min_a   [NUM_CH];
  logic [CNT_W-1:0] max_a   [NUM_CH];
  logic [CNT_W-1:0] ivl_a   [NUM_CH];
  logic [CNT_W-1:0] stall_a [NUM_CH];
  logic [3:0]       stat_a  [NUM_CH];

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    st_e              st_q, st_d;
    logic [CNT_W-1:0] lat_q, lat_d, s2s_q, s2s_d;
    logic [CNT_W-1:0] txn_q, txn_d, last_q, last_d;
    logic [CNT_W-1:0] min_q, min_d, max_q, max_d;
    logic [CNT_W-1:0] ivl_q, ivl_d, stall_q, stall_d;
    logic             ovf_q, ovf_d, hs_q, hs_d;
    logic [CNT_W:0]   lat_inc, s2s_inc, txn_inc, stall_inc;
    logic             start_ev;

    always_comb begin
      st_d      = st_q;
      lat_d     = lat_q;
      s2s_d     = s2s_q;
      txn_d     = txn_q;
      last_d    = last_q;
      min_d     = min_q;
      max_d     = max_q;
      ivl_d     = ivl_q;
      stall_d   = stall_q;
      ovf_d     = ovf_q;
      hs_d      = hs_q;
      start_ev  = 1'b0;
      lat_inc   = sinc(lat_q);
      s2s_inc   = sinc(s2s_q);
      txn_inc   = sinc(txn_q);
      stall_inc = sinc(stall_q);

      if (hs_q) begin
        s2s_d = s2s_inc[CNT_W-1:0];
        ovf_d = ovf_d | s2s_inc[CNT_W];
      end

      unique case (st_q)
        S_IDLE: start_ev = ch_ap_start[c];
        S_BUSY: begin
          lat_d = lat_inc[CNT_W-1:0];
          ovf_d = ovf_d | lat_inc[CNT_W];
          if (ch_ap_done[c]) begin
            last_d = lat_inc[CNT_W-1:0];
            txn_d  = txn_inc[CNT_W-1:0];
            ovf_d  = ovf_d | txn_inc[CNT_W];
            if (lat_inc[CNT_W-1:0] < min_q) min_d = lat_inc[CNT_W-1:0];
            if (lat_inc[CNT_W-1:0] > max_q) max_d = lat_inc[CNT_W-1:0];
            if (!ch_ap_continue[c]) st_d = S_WAIT;
            else if (ch_ap_start[c]) start_ev = 1'b1;
            else st_d = S_IDLE;
          end
        end
        S_WAIT: begin
          stall_d = stall_inc[CNT_W-1:0];
          ovf_d   = ovf_d | stall_inc[CNT_W];
          if (ch_ap_continue[c]) begin
            if (ch_ap_start[c]) start_ev = 1'b1;
            else st_d = S_IDLE;
          end
        end
        default: st_d = S_IDLE;
      endcase

      // Interval is measured start-to-start, so it is captured on the start.
      if (start_ev) begin
        st_d  = S_BUSY;
        lat_d = '0;
        s2s_d = '0;
        hs_d  = 1'b1;
        if (hs_q) ivl_d = s2s_inc[CNT_W-1:0];
      end

      if (clear) begin
        st_d    = S_IDLE;
        lat_d   = '0;
        s2s_d   = '0;
        txn_d   = '0;
        last_d  = '0;
        min_d   = '1;
        max_d   = '0;
        ivl_d   = '0;
        stall_d = '0;
        ovf_d   = 1'b0;
        hs_d    = 1'b0;
      end
    end

    always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
        st_q    <= S_IDLE;
        lat_q   <= '0;
        s2s_q   <= '0;
        txn_q   <= '0;
        last_q  <= '0;
        min_q   <= '1;
        max_q   <= '0;
        ivl_q   <= '0;
        stall_q <= '0;
        ovf_q   <= 1'b0;
        hs_q    <= 1'b0;
      end else if (clear || !freeze) begin
        st_q    <= st_d;
        lat_q   <= lat_d;
        s2s_q   <= s2s_d;
        txn_q   <= txn_d;
        last_q  <= last_d;
        min_q   <= min_d;
        max_q   <= max_d;
        ivl_q   <= ivl_d;
        stall_q <= stall_d;
        ovf_q   <= ovf_d;
        hs_q    <= hs_d;
      end
    end

    assign ch_busy[c] = (st_q != S_IDLE);
    assign txn_a[c]   = txn_q;
    assign last_a[c]  = last_q;
    assign min_a[c]   = min_q;
    assign max_a[c]   = max_q;
    assign ivl_a[c]   = ivl_q;
    assign stall_a[c] = stall_q;
    assign stat_a[c]  = {ovf_q, hs_q, st_q};
  end

  logic [CNT_W-1:0] rd_mux;
  logic             rd_valid_q;
  logic [CNT_W-1:0] rd_data_q;

  always_comb begin
    rd_mux = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (rd_ch == 3'(i)) begin
        unique case (rd_sel)
          3'd0:    rd_mux = txn_a[i];
          3'd1:    rd_mux = last_a[i];
          3'd2:    rd_mux = min_a[i];
          3'd3:    rd_mux = max_a[i];
          3'd4:    rd_mux = ivl_a[i];
          3'd5:    rd_mux = stall_a[i];
          3'd6:    rd_mux = {{(CNT_W-4){1'b0}}, stat_a[i]};
          default: rd_mux = '0;
        endcase
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
      frozen_q   <= 1'b0;
    end else begin
      rd_valid_q <= rd_en;
      rd_data_q  <= rd_en ? rd_mux : '0;
      frozen_q   <= frozen_d;
    end
  end

  assign rd_valid = rd_valid_q;
  assign rd_data  = rd_data_q;

endmodule

// File: tb/tb_ap_ctrl_perf_monitor.sv
// Scoreboard bench for ap_ctrl_perf_monitor: reads push expectations,
// the rd_valid monitors pop and compare.
module tb_ap_ctrl_perf_monitor;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]  st, dn, ct;
  logic        finish, clear, rd_en;
  logic [2:0]  rd_ch, rd_sel;
  logic        rd_valid;
  logic [31:0] rd_data;
  logic [1:0]  busy;
  logic        frozen;

  logic        s_st, s_dn, s_ct, s_rd_en;
  logic [2:0]  s_rd_ch, s_rd_sel;
  logic        s_rd_valid;
  logic [7:0]  s_rd_data;
  logic        s_busy, s_frozen;

  int n_chk = 0;
  int n_err = 0;

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } sb_t;

  sb_t sb0[$];
  sb_t sb1[$];

  ap_ctrl_perf_monitor #(.NUM_CH(2), .CNT_W(32)) u_dut (
    .clock(clk), .reset(rst_n),
    .ch_ap_start(st), .ch_ap_done(dn), .ch_ap_continue(ct),
    .finish(finish), .clear(clear),
    .rd_en(rd_en), .rd_ch(rd_ch), .rd_sel(rd_sel),
    .rd_valid(rd_valid), .rd_data(rd_data),
    .ch_busy(busy), .frozen(frozen)
  );

  ap_ctrl_perf_monitor #(.NUM_CH(1), .CNT_W(8)) u_dut8 (
    .clock(clk), .reset(rst_n),
    .ch_ap_start(s_st), .ch_ap_done(s_dn), .ch_ap_continue(s_ct),
    .finish(finish), .clear(clear),
    .rd_en(s_rd_en), .rd_ch(s_rd_ch), .rd_sel(s_rd_sel),
    .rd_valid(s_rd_valid), .rd_data(s_rd_data),
    .ch_busy(s_busy), .frozen(s_frozen)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [2:0] ch, input logic [2:0] sel,
                    input logic [31:0] exp, input string tag);
    sb_t e;
    e.tag = tag;
    e.exp = exp;
    rd_ch  = ch;
    rd_sel = sel;
    rd_en  = 1'b1;
    sb0.push_back(e);
    tick();
    rd_en = 1'b0;
  endtask

  task automatic rd8(input logic [2:0] sel, input logic [31:0] exp,
                     input string tag);
    sb_t e;
    e.tag = tag;
    e.exp = exp;
    s_rd_ch  = 3'd0;
    s_rd_sel = sel;
    s_rd_en  = 1'b1;
    sb1.push_back(e);
    tick();
    s_rd_en = 1'b0;
  endtask

  always @(negedge clk) begin
    sb_t e;
    if (rd_valid) begin
      if (sb0.size() == 0) chk("sb0_spurious", 32'(rd_valid), 32'd0);
      else begin
        e = sb0.pop_front();
        chk(e.tag, rd_data, e.exp);
      end
    end
    if (s_rd_valid) begin
      if (sb1.size() == 0) chk("sb1_spurious", 32'(s_rd_valid), 32'd0);
      else begin
        e = sb1.pop_front();
        chk(e.tag, 32'(s_rd_data), e.exp);
      end
    end
  end

  initial begin
    st = '0; dn = '0; ct = 2'b11;
    finish = 1'b0; clear = 1'b0;
    rd_en = 1'b0; rd_ch = '0; rd_sel = '0;
    s_st = 1'b0; s_dn = 1'b0; s_ct = 1'b1;
    s_rd_en = 1'b0; s_rd_ch = '0; s_rd_sel = '0;

    repeat (3) @(negedge clk);
    chk("rst_valid", 32'(rd_valid), 32'd0);
    chk("rst_data", rd_data, 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_frozen", 32'(frozen), 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // ch0: start 10 / done 14; ch1: start 10, done 20, stall to 23, restart 23
    for (int c = 0; c < 26; c++) begin
      st = {1'(c == 10 || c == 23), 1'(c == 10)};
      dn = {1'(c == 20), 1'(c == 14)};
      ct = {1'(!(c >= 20 && c < 23)), 1'b1};
      rd_en = 1'(c == 14);
      rd_ch = 3'd0;
      rd_sel = 3'd0;
      if (c == 14) sb0.push_back('{tag: "txn_pre_update", exp: 32'd0});
      @(negedge clk);
      chk($sformatf("busy_c%0d", c), 32'(busy),
          32'({1'(c >= 11), 1'(c >= 11 && c <= 14)}));
      tick();
    end
    st = '0; dn = '0; ct = 2'b11; rd_en = 1'b0;

    rd(3'd0, 3'd0, 32'd1, "c0_txn");
    rd(3'd0, 3'd1, 32'd4, "c0_last");
    rd(3'd0, 3'd2, 32'd4, "c0_min");
    rd(3'd0, 3'd3, 32'd4, "c0_max");
    rd(3'd0, 3'd4, 32'd0, "c0_ivl");
    rd(3'd0, 3'd6, 32'd4, "c0_stat");
    rd(3'd1, 3'd0, 32'd1, "c1_txn");
    rd(3'd1, 3'd1, 32'd10, "c1_last");
    rd(3'd1, 3'd4, 32'd13, "c1_ivl");
    rd(3'd1, 3'd5, 32'd3, "c1_stall");
    rd(3'd1, 3'd6, 32'd5, "c1_stat");

    // clear wins over finish in the same cycle
    clear = 1'b1; finish = 1'b1;
    tick();
    clear = 1'b0; finish = 1'b0;
    @(negedge clk);
    chk("clr_frozen", 32'(frozen), 32'd0);
    chk("clr_busy", 32'(busy), 32'd0);
    rd(3'd1, 3'd0, 32'd0, "clr_c1_txn");
    rd(3'd1, 3'd2, 32'hFFFF_FFFF, "clr_c1_min");
    rd(3'd1, 3'd5, 32'd0, "clr_c1_stall");
    rd(3'd1, 3'd6, 32'd0, "clr_c1_stat");

    // back-to-back on ch0: latencies 4 then 6
    for (int k = 0; k < 12; k++) begin
      st = {1'b0, 1'(k == 0 || k == 4)};
      dn = {1'b0, 1'(k == 4 || k == 10)};
      tick();
    end
    st = '0; dn = '0;
    rd(3'd0, 3'd0, 32'd2, "b2b_txn");
    rd(3'd0, 3'd2, 32'd4, "b2b_min");
    rd(3'd0, 3'd3, 32'd6, "b2b_max");
    rd(3'd0, 3'd1, 32'd6, "b2b_last");
    rd(3'd0, 3'd4, 32'd4, "b2b_ivl");

    // finish during BUSY; a done while frozen must be ignored
    for (int k = 0; k < 60; k++) begin
      st = {1'b0, 1'(k == 0)};
      finish = 1'(k == 3);
      dn = {1'b0, 1'(k == 10)};
      tick();
    end
    st = '0; dn = '0; finish = 1'b0;
    @(negedge clk);
    chk("frz_frozen", 32'(frozen), 32'd1);
    chk("frz_busy", 32'(busy), 32'd1);
    rd(3'd0, 3'd6, 32'd5, "frz_stat");
    rd(3'd0, 3'd0, 32'd2, "frz_txn");
    rd(3'd0, 3'd1, 32'd6, "frz_last");
    clear = 1'b1;
    tick();
    clear = 1'b0;
    @(negedge clk);
    chk("clr2_frozen", 32'(frozen), 32'd0);
    rd(3'd0, 3'd0, 32'd0, "clr2_txn");
    rd(3'd0, 3'd1, 32'd0, "clr2_last");
    rd(3'd0, 3'd2, 32'hFFFF_FFFF, "clr2_min");
    rd(3'd0, 3'd3, 32'd0, "clr2_max");
    rd(3'd0, 3'd6, 32'd0, "clr2_stat");

    rd(3'd5, 3'd0, 32'd0, "bad_ch");
    rd(3'd0, 3'd7, 32'd0, "bad_sel");

    // one txn, then reset in the middle of a second one
    for (int k = 0; k < 6; k++) begin
      st = {1'b0, 1'(k == 0 || k == 4)};
      dn = {1'b0, 1'(k == 2)};
      tick();
    end
    st = '0; dn = '0;
    rd(3'd0, 3'd0, 32'd1, "prerst_txn");
    rd(3'd0, 3'd1, 32'd2, "prerst_last");
    @(negedge clk);
    chk("prerst_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    rd_en = 1'b1;
    repeat (2) @(negedge clk);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_valid", 32'(rd_valid), 32'd0);
    rd_en = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    rd(3'd0, 3'd6, 32'd0, "postrst_stat");
    rd(3'd0, 3'd0, 32'd0, "postrst_txn");

    // 8-bit instance: latency 300 saturates
    for (int k = 0; k < 302; k++) begin
      s_st = 1'(k == 0);
      s_dn = 1'(k == 300);
      tick();
    end
    s_st = 1'b0; s_dn = 1'b0;
    rd8(3'd1, 32'd255, "w8_last");
    rd8(3'd0, 32'd1, "w8_txn");
    rd8(3'd3, 32'd255, "w8_max");
    rd8(3'd6, 32'd12, "w8_stat");

    repeat (3) tick();
    chk("sb0_drain", 32'(sb0.size()), 32'd0);
    chk("sb1_drain", 32'(sb1.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
